// File: rtl/game_flow_ctrl.sv
// Game sequencer: lives, score, wave progression and respawn/game-over timing.
// Define HIGH_SCORE_EN to keep a best-score register; otherwise hiscore_o is tied to 0.
module game_flow_ctrl #(
  parameter int lives_p          = 3,
  parameter int respawn_frames_p = 120,
  parameter int wave_frames_p    = 60,
  parameter int over_frames_p    = 180,
  parameter int enemy_points_p   = 10,
  parameter int score_width_p    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_i,
  input  logic                     start_i,
  input  logic                     player_was_hit_i,
  input  logic                     enemy_was_hit_i,
  input  logic                     wave_cleared_i,
  input  logic                     enemy_landed_i,
  output logic                     play_en_o,
  output logic                     player_reset_o,
  output logic                     wave_reset_o,
  output logic                     blink_o,
  output logic [2:0]               state_o,
  output logic [2:0]               lives_o,
  output logic [3:0]               wave_o,
  output logic [score_width_p-1:0] score_o,
  output logic [score_width_p-1:0] hiscore_o,
  output logic                     score_valid_o,
  input  logic                     score_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WAVE = 3'd3,
    S_OVER = 3'd4
  } state_t;

  localparam int max_frames = (respawn_frames_p > wave_frames_p)
                              ? ((respawn_frames_p > over_frames_p) ? respawn_frames_p : over_frames_p)
                              : ((wave_frames_p > over_frames_p) ? wave_frames_p : over_frames_p);
  localparam int timer_raw_w = $clog2(max_frames + 1);
  // At least 4 bits so the blink tap (bit 3) always exists.
  localparam int timer_w = (timer_raw_w < 4) ? 4 : timer_raw_w;

  localparam logic [timer_w-1:0] respawn_tc = timer_w'(respawn_frames_p);
  localparam logic [timer_w-1:0] wave_tc    = timer_w'(wave_frames_p);
  localparam logic [timer_w-1:0] over_tc    = timer_w'(over_frames_p);
  localparam logic [score_width_p-1:0] score_max = '1;

  state_t                   state_q, state_d;
  logic [timer_w-1:0]       timer_q, timer_d;
  logic [timer_w-1:0]       timer_tc;
  logic [2:0]               lives_q, lives_d;
  logic [3:0]               wave_q, wave_d;
  logic [score_width_p-1:0] score_q, score_d;
  logic [score_width_p:0]   score_sum;
  logic                     start_q, start_d;
  logic                     start_rise;
  logic                     player_reset_q, player_reset_d;
  logic                     wave_reset_q, wave_reset_d;
  logic                     score_valid_q, score_valid_d;
  logic                     new_game;

  assign start_rise = start_i && !start_q;
  assign score_sum  = {1'b0, score_q} + (score_width_p + 1)'(enemy_points_p);

  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    wave_d         = wave_q;
    score_d        = score_q;
    player_reset_d = 1'b0;
    wave_reset_d   = 1'b0;
    new_game       = 1'b0;
    start_d        = start_i;

    case (state_q)
      S_IDLE: begin
        if (start_rise) new_game = 1'b1;
      end
      S_PLAY: begin
        // Kills are scored even when a hit or landing ends PLAY in the same cycle.
        if (enemy_was_hit_i) score_d = score_sum[score_width_p] ? score_max : score_sum[score_width_p-1:0];
        if (enemy_landed_i) begin
          state_d = S_OVER;
          lives_d = 3'd0;
        end else if (player_was_hit_i) begin
          lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          state_d = (lives_q <= 3'd1) ? S_OVER : S_HIT;
        end else if (wave_cleared_i) begin
          state_d = S_WAVE;
          wave_d  = wave_q + 4'd1;
        end
      end
      S_HIT: begin
        if (timer_q == respawn_tc) begin
          state_d        = S_PLAY;
          player_reset_d = 1'b1;
        end
      end
      S_WAVE: begin
        if (timer_q == wave_tc) begin
          state_d        = S_PLAY;
          player_reset_d = 1'b1;
          wave_reset_d   = 1'b1;
        end
      end
      S_OVER: begin
        if (timer_q == over_tc && start_rise) new_game = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (new_game) begin
      state_d        = S_PLAY;
      lives_d        = 3'(lives_p);
      wave_d         = 4'd0;
      score_d        = '0;
      player_reset_d = 1'b1;
      wave_reset_d   = 1'b1;
    end
  end

  always_comb begin
    case (state_q)
      S_HIT:   timer_tc = respawn_tc;
      S_WAVE:  timer_tc = wave_tc;
      S_OVER:  timer_tc = over_tc;
      default: timer_tc = '0;
    endcase
    timer_d = timer_q;
    if (state_d != state_q)                timer_d = '0;
    else if (frame_i && timer_q < timer_tc) timer_d = timer_q + 1'b1;
  end

  always_comb begin
    score_valid_d = score_valid_q;
    if (score_d != score_q)                  score_valid_d = 1'b1;
    else if (score_valid_q && score_ready_i) score_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      lives_q        <= 3'd0;
      wave_q         <= 4'd0;
      score_q        <= '0;
      start_q        <= 1'b0;
      player_reset_q <= 1'b0;
      wave_reset_q   <= 1'b0;
      score_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lives_q        <= lives_d;
      wave_q         <= wave_d;
      score_q        <= score_d;
      start_q        <= start_d;
      player_reset_q <= player_reset_d;
      wave_reset_q   <= wave_reset_d;
      score_valid_q  <= score_valid_d;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [score_width_p-1:0] hiscore_q, hiscore_d;

  // Compare against the incoming score so a kill in the final PLAY cycle counts.
  always_comb begin
    hiscore_d = hiscore_q;
    if (state_d == S_OVER && state_q != S_OVER && score_d > hiscore_q) hiscore_d = score_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) hiscore_q <= '0;
    else         hiscore_q <= hiscore_d;
  end

  assign hiscore_o = hiscore_q;
`else
  assign hiscore_o = '0;
`endif

  assign play_en_o      = (state_q == S_PLAY);
  assign player_reset_o = player_reset_q;
  assign wave_reset_o   = wave_reset_q;
  assign blink_o        = (state_q == S_HIT) && (timer_q != respawn_tc) && timer_q[3];
  assign state_o        = state_q;
  assign lives_o        = lives_q;
  assign wave_o         = wave_q;
  assign score_o        = score_q;
  assign score_valid_o  = score_valid_q;

endmodule
